// File: rtl/stack_pkg.sv
// Shared definitions for the stack call/return controller: FSM state
// encoding, fault codes and default stack-pointer bounds.
`timescale 1ns/1ps
package stack_pkg;

   // Controller states; the two-byte push and pop sequences each have their own states
   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      PUSH_HI = 3'd1,
      PUSH_LO = 3'd2,
      POP_LO  = 3'd3,
      POP_HI  = 3'd4,
      POP_CAP = 3'd5,
      DONE    = 3'd6
   } state_e;

   // Fault codes reported on fault_code
   localparam logic [1:0] FAULT_NONE      = 2'b00;
   localparam logic [1:0] FAULT_OVERFLOW  = 2'b01;
   localparam logic [1:0] FAULT_UNDERFLOW = 2'b10;
   localparam logic [1:0] FAULT_CONFLICT  = 2'b11;

   // Default stack bounds: full downward range of a 16-bit pointer
   localparam logic [15:0] SP_LIMIT_DEFAULT = 16'h0000;
   localparam logic [15:0] SP_EMPTY_DEFAULT = 16'hFFFF;

endpackage

// File: rtl/stack_call_ctrl.sv
// Initiator-side controller for the byte-wide hardware stack. A call saves a
// 16-bit return address as two pushes (high byte first); a return pops two
// bytes (low byte first) and hands the reassembled address to the PC.
// The stack pointer is range-checked once, before any strobe is issued, so a
// rejected request never leaves half an address on the stack.
`timescale 1ns/1ps
module stack_call_ctrl
   import stack_pkg::*;
#(
   parameter logic [15:0] SP_LIMIT = SP_LIMIT_DEFAULT,
   parameter logic [15:0] SP_EMPTY = SP_EMPTY_DEFAULT
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        call_req,
   input  logic        ret_req,
   input  logic [15:0] ret_addr_in,
   input  logic        fault_clr,
   input  logic [15:0] sp_ptr,
   input  logic [7:0]  sp_data_out,
   output logic        sp_enable,
   output logic        sp_decrement,
   output logic        sp_increment,
   output logic [7:0]  sp_data_in,
   output logic        busy,
   output logic        done,
   output logic        pc_load,
   output logic [15:0] pc_out,
   output logic        fault,
   output logic [1:0]  fault_code
);

   state_e      state_q;
   logic [15:0] retAddr_q;
   logic [7:0]  popLo_q;
   logic        spEnable_q;
   logic        spDecrement_q;
   logic        spIncrement_q;
   logic [7:0]  spDataIn_q;
   logic        busy_q;
   logic        done_q;
   logic        pcLoad_q;
   logic [15:0] pcOut_q;
   logic        fault_q;
   logic [1:0]  faultCode_q;

   logic [16:0] spWide;
   logic        overflow;
   logic        underflow;
   logic        faultHit;
   logic [1:0]  faultKind;

   // 17-bit compares so the +2 margins cannot wrap at either end of the range
   assign spWide    = {1'b0, sp_ptr};
   assign overflow  = spWide < ({1'b0, SP_LIMIT} + 17'd2);
   assign underflow = (spWide + 17'd2) > {1'b0, SP_EMPTY};

   // Decide whether a request seen in IDLE must be rejected, and with which code
   always_comb begin
      faultHit  = 1'b0;
      faultKind = FAULT_NONE;
      if (state_q == IDLE && !fault_q) begin
         if (call_req && ret_req) begin
            faultHit  = 1'b1;
            faultKind = FAULT_CONFLICT;
         end else if (call_req && overflow) begin
            faultHit  = 1'b1;
            faultKind = FAULT_OVERFLOW;
         end else if (ret_req && underflow) begin
            faultHit  = 1'b1;
            faultKind = FAULT_UNDERFLOW;
         end
      end
   end

   // Sequencer with registered outputs: each transition also loads the outputs of the state being entered
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q       <= IDLE;
         retAddr_q     <= 16'h0000;
         popLo_q       <= 8'h00;
         spEnable_q    <= 1'b0;
         spDecrement_q <= 1'b0;
         spIncrement_q <= 1'b0;
         spDataIn_q    <= 8'h00;
         busy_q        <= 1'b0;
         done_q        <= 1'b0;
         pcLoad_q      <= 1'b0;
         pcOut_q       <= 16'h0000;
         fault_q       <= 1'b0;
         faultCode_q   <= FAULT_NONE;
      end else begin
         spEnable_q    <= 1'b0;
         spDecrement_q <= 1'b0;
         spIncrement_q <= 1'b0;
         spDataIn_q    <= 8'h00;
         busy_q        <= 1'b1;
         done_q        <= 1'b0;
         pcLoad_q      <= 1'b0;

         if (fault_clr) begin
            fault_q     <= 1'b0;
            faultCode_q <= FAULT_NONE;
         end else if (faultHit) begin
            fault_q     <= 1'b1;
            faultCode_q <= faultKind;
         end

         unique case (state_q)
            IDLE: begin
               busy_q <= 1'b0;
               if (!fault_q && !faultHit && call_req) begin
                  retAddr_q     <= ret_addr_in;
                  state_q       <= PUSH_HI;
                  spEnable_q    <= 1'b1;
                  spDecrement_q <= 1'b1;
                  spDataIn_q    <= ret_addr_in[15:8];
                  busy_q        <= 1'b1;
               end else if (!fault_q && !faultHit && ret_req) begin
                  state_q       <= POP_LO;
                  spEnable_q    <= 1'b1;
                  spIncrement_q <= 1'b1;
                  busy_q        <= 1'b1;
               end
            end
            PUSH_HI: begin
               state_q       <= PUSH_LO;
               spEnable_q    <= 1'b1;
               spDecrement_q <= 1'b1;
               spDataIn_q    <= retAddr_q[7:0];
            end
            PUSH_LO: begin
               state_q <= DONE;
               done_q  <= 1'b1;
            end
            POP_LO: begin
               state_q       <= POP_HI;
               spEnable_q    <= 1'b1;
               spIncrement_q <= 1'b1;
            end
            POP_HI: begin
               popLo_q <= sp_data_out;
               state_q <= POP_CAP;
            end
            POP_CAP: begin
               pcOut_q  <= {sp_data_out, popLo_q};
               state_q  <= DONE;
               done_q   <= 1'b1;
               pcLoad_q <= 1'b1;
            end
            DONE: begin
               state_q <= IDLE;
               busy_q  <= 1'b0;
            end
            default: begin
               state_q <= IDLE;
               busy_q  <= 1'b0;
            end
         endcase
      end
   end

   assign sp_enable    = spEnable_q;
   assign sp_decrement = spDecrement_q;
   assign sp_increment = spIncrement_q;
   assign sp_data_in   = spDataIn_q;
   assign busy         = busy_q;
   assign done         = done_q;
   assign pc_load      = pcLoad_q;
   assign pc_out       = pcOut_q;
   assign fault        = fault_q;
   assign fault_code   = faultCode_q;

endmodule

// File: tb/tb_stack_call_ctrl.sv
// Self-checking bench for stack_call_ctrl. A byte-array stack model answers
// the strobes; a queue of saved addresses predicts what each return restores.
`timescale 1ns/1ps
module tb_stack_call_ctrl;
   import stack_pkg::*;

   logic        clk = 1'b0;
   logic        reset;
   logic        call_req;
   logic        ret_req;
   logic [15:0] ret_addr_in;
   logic        fault_clr;
   logic [15:0] sp_ptr;
   logic [7:0]  sp_data_out;
   logic        sp_enable;
   logic        sp_decrement;
   logic        sp_increment;
   logic [7:0]  sp_data_in;
   logic        busy;
   logic        done;
   logic        pc_load;
   logic [15:0] pc_out;
   logic        fault;
   logic [1:0]  fault_code;

   int checks = 0;
   int errors = 0;

   bit   [7:0]  mem [0:65535];
   logic [15:0] spPtr = 16'h8000;
   logic [7:0]  spDataOut = 8'h00;
   logic        spLoadReq = 1'b0;
   logic [15:0] spLoadVal = 16'h0000;
   int          pushCount = 0;
   int          popCount = 0;

   stack_call_ctrl dut (
      .clk         (clk),
      .reset       (reset),
      .call_req    (call_req),
      .ret_req     (ret_req),
      .ret_addr_in (ret_addr_in),
      .fault_clr   (fault_clr),
      .sp_ptr      (sp_ptr),
      .sp_data_out (sp_data_out),
      .sp_enable   (sp_enable),
      .sp_decrement(sp_decrement),
      .sp_increment(sp_increment),
      .sp_data_in  (sp_data_in),
      .busy        (busy),
      .done        (done),
      .pc_load     (pc_load),
      .pc_out      (pc_out),
      .fault       (fault),
      .fault_code  (fault_code)
   );

   always #5 clk = ~clk;

   assign sp_ptr      = spPtr;
   assign sp_data_out = spDataOut;

   // Downward-growing byte stack: push writes at the pointer then decrements, pop increments then reads
   always @(posedge clk) begin
      if (spLoadReq) begin
         spPtr <= spLoadVal;
      end else if (sp_enable && sp_decrement) begin
         mem[spPtr] <= sp_data_in;
         spPtr      <= spPtr - 16'd1;
         pushCount  <= pushCount + 1;
      end else if (sp_enable && sp_increment) begin
         spDataOut <= mem[spPtr + 16'd1];
         spPtr     <= spPtr + 16'd1;
         popCount  <= popCount + 1;
      end
   end

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic applyStimulus(input logic c, input logic r, input logic [15:0] a, input logic clr);
      call_req    = c;
      ret_req     = r;
      ret_addr_in = a;
      fault_clr   = clr;
   endtask

   task automatic setSp(input logic [15:0] v);
      spLoadVal = v;
      spLoadReq = 1'b1;
      tick(1);
      spLoadReq = 1'b0;
   endtask

   task automatic test_reset;
      reset = 1'b1;
      applyStimulus(1'b0, 1'b0, 16'h0000, 1'b0);
      #1 reset = 1'b0;
      #1;
      checks++;
      if ({sp_enable, sp_decrement, sp_increment} !== 3'b000) begin
         errors++; $display("[TB] FAIL reset_strobes got %b expected 000", {sp_enable, sp_decrement, sp_increment});
      end
      checks++;
      if (sp_data_in !== 8'h00) begin
         errors++; $display("[TB] FAIL reset_data got %h expected 00", sp_data_in);
      end
      checks++;
      if ({busy, done, pc_load} !== 3'b000) begin
         errors++; $display("[TB] FAIL reset_flags got %b expected 000", {busy, done, pc_load});
      end
      checks++;
      if (pc_out !== 16'h0000) begin
         errors++; $display("[TB] FAIL reset_pc got %h expected 0000", pc_out);
      end
      checks++;
      if ({fault, fault_code} !== 3'b000) begin
         errors++; $display("[TB] FAIL reset_fault got %b expected 000", {fault, fault_code});
      end
      tick(2);
      reset = 1'b1;
      tick(1);
   endtask

   task automatic test_call;
      logic [15:0] a;
      int p0;
      a = 16'h1234;
      setSp(16'h0100);
      p0 = pushCount;
      applyStimulus(1'b1, 1'b0, a, 1'b0);
      tick(1);
      applyStimulus(1'b0, 1'b0, 16'h0000, 1'b0);
      checks++;
      if ({busy, sp_enable, sp_decrement, sp_increment} !== 4'b1110 || sp_data_in !== a[15:8]) begin
         errors++; $display("[TB] FAIL call_t1 got %b/%h expected 1110/%h", {busy, sp_enable, sp_decrement, sp_increment}, sp_data_in, a[15:8]);
      end
      tick(1);
      checks++;
      if ({busy, sp_enable, sp_decrement, sp_increment} !== 4'b1110 || sp_data_in !== a[7:0]) begin
         errors++; $display("[TB] FAIL call_t2 got %b/%h expected 1110/%h", {busy, sp_enable, sp_decrement, sp_increment}, sp_data_in, a[7:0]);
      end
      tick(1);
      checks++;
      if ({busy, done, sp_enable, pc_load} !== 4'b1100) begin
         errors++; $display("[TB] FAIL call_t3 got %b expected 1100", {busy, done, sp_enable, pc_load});
      end
      tick(1);
      checks++;
      if ({busy, done, sp_enable} !== 3'b000 || sp_data_in !== 8'h00) begin
         errors++; $display("[TB] FAIL call_t4 got %b/%h expected 000/00", {busy, done, sp_enable}, sp_data_in);
      end
      checks++;
      if (pushCount - p0 !== 2 || spPtr !== 16'h00FE || mem[16'h0100] !== 8'h12 || mem[16'h00FF] !== 8'h34) begin
         errors++; $display("[TB] FAIL call_stack got pushes=%0d sp=%h expected 2/00FE", pushCount - p0, spPtr);
      end
   endtask

   task automatic test_return;
      int p0;
      int q0;
      setSp(16'h00FE);
      p0 = popCount;
      q0 = pushCount;
      applyStimulus(1'b0, 1'b1, 16'h0000, 1'b0);
      tick(1);
      applyStimulus(1'b0, 1'b0, 16'h0000, 1'b0);
      checks++;
      if ({busy, sp_enable, sp_decrement, sp_increment} !== 4'b1101) begin
         errors++; $display("[TB] FAIL ret_t1 got %b expected 1101", {busy, sp_enable, sp_decrement, sp_increment});
      end
      tick(1);
      checks++;
      if ({busy, sp_enable, sp_decrement, sp_increment} !== 4'b1101) begin
         errors++; $display("[TB] FAIL ret_t2 got %b expected 1101", {busy, sp_enable, sp_decrement, sp_increment});
      end
      tick(1);
      checks++;
      if ({busy, sp_enable, done, pc_load} !== 4'b1000) begin
         errors++; $display("[TB] FAIL ret_t3 got %b expected 1000", {busy, sp_enable, done, pc_load});
      end
      tick(1);
      checks++;
      if ({done, pc_load} !== 2'b11 || pc_out !== 16'h1234) begin
         errors++; $display("[TB] FAIL ret_t4 got %b/%h expected 11/1234", {done, pc_load}, pc_out);
      end
      tick(1);
      checks++;
      if ({busy, done, pc_load} !== 3'b000 || pc_out !== 16'h1234) begin
         errors++; $display("[TB] FAIL ret_hold got %b/%h expected 000/1234", {busy, done, pc_load}, pc_out);
      end
      checks++;
      if (popCount - p0 !== 2 || pushCount - q0 !== 0) begin
         errors++; $display("[TB] FAIL ret_counts got pops=%0d pushes=%0d expected 2/0", popCount - p0, pushCount - q0);
      end
   endtask

   task automatic test_overflow;
      int p0;
      int q0;
      setSp(16'h0001);
      p0 = pushCount;
      applyStimulus(1'b1, 1'b0, 16'hABCD, 1'b0);
      tick(1);
      applyStimulus(1'b0, 1'b0, 16'h0000, 1'b0);
      checks++;
      if ({sp_enable, busy, fault, fault_code} !== 5'b00101) begin
         errors++; $display("[TB] FAIL ovf_fault got %b expected 00101", {sp_enable, busy, fault, fault_code});
      end
      setSp(16'h8000);
      q0 = popCount;
      applyStimulus(1'b0, 1'b1, 16'h0000, 1'b0);
      tick(4);
      applyStimulus(1'b0, 1'b0, 16'h0000, 1'b0);
      checks++;
      if (popCount - q0 !== 0 || pushCount - p0 !== 0 || {fault, fault_code} !== 3'b101) begin
         errors++; $display("[TB] FAIL ovf_sticky got pops=%0d pushes=%0d flt=%b expected 0/0/101", popCount - q0, pushCount - p0, {fault, fault_code});
      end
      applyStimulus(1'b0, 1'b0, 16'h0000, 1'b1);
      tick(1);
      applyStimulus(1'b0, 1'b0, 16'h0000, 1'b0);
      checks++;
      if ({fault, fault_code} !== 3'b000) begin
         errors++; $display("[TB] FAIL ovf_clear got %b expected 000", {fault, fault_code});
      end
      setSp(16'h0002);
      p0 = pushCount;
      applyStimulus(1'b1, 1'b0, 16'h5A5A, 1'b0);
      tick(1);
      applyStimulus(1'b0, 1'b0, 16'h0000, 1'b0);
      tick(3);
      checks++;
      if (pushCount - p0 !== 2 || fault !== 1'b0) begin
         errors++; $display("[TB] FAIL ovf_edge got pushes=%0d fault=%b expected 2/0", pushCount - p0, fault);
      end
      setSp(16'h0001);
      p0 = pushCount;
      applyStimulus(1'b1, 1'b0, 16'h1111, 1'b1);
      tick(1);
      applyStimulus(1'b0, 1'b0, 16'h0000, 1'b0);
      checks++;
      if (fault !== 1'b0 || sp_enable !== 1'b0) begin
         errors++; $display("[TB] FAIL clr_priority got fault=%b en=%b expected 0/0", fault, sp_enable);
      end
      tick(3);
   endtask

   task automatic test_underflow;
      int p0;
      int q0;
      setSp(16'hFFFE);
      p0 = popCount;
      applyStimulus(1'b0, 1'b1, 16'h0000, 1'b0);
      tick(1);
      applyStimulus(1'b0, 1'b0, 16'h0000, 1'b0);
      checks++;
      if ({sp_enable, busy, fault, fault_code} !== 5'b00110) begin
         errors++; $display("[TB] FAIL udf_fault got %b expected 00110", {sp_enable, busy, fault, fault_code});
      end
      tick(2);
      checks++;
      if (popCount - p0 !== 0) begin
         errors++; $display("[TB] FAIL udf_nopop got %0d expected 0", popCount - p0);
      end
      applyStimulus(1'b0, 1'b0, 16'h0000, 1'b1);
      tick(1);
      setSp(16'hFFFD);
      p0 = popCount;
      applyStimulus(1'b0, 1'b1, 16'h0000, 1'b0);
      tick(1);
      applyStimulus(1'b0, 1'b0, 16'h0000, 1'b0);
      tick(4);
      checks++;
      if (popCount - p0 !== 2 || fault !== 1'b0) begin
         errors++; $display("[TB] FAIL udf_edge got pops=%0d fault=%b expected 2/0", popCount - p0, fault);
      end
      setSp(16'h8000);
      p0 = popCount;
      q0 = pushCount;
      applyStimulus(1'b1, 1'b1, 16'h2222, 1'b0);
      tick(1);
      applyStimulus(1'b0, 1'b0, 16'h0000, 1'b0);
      checks++;
      if ({sp_enable, fault, fault_code} !== 4'b0111) begin
         errors++; $display("[TB] FAIL conflict got %b expected 0111", {sp_enable, fault, fault_code});
      end
      tick(3);
      checks++;
      if (popCount - p0 !== 0 || pushCount - q0 !== 0) begin
         errors++; $display("[TB] FAIL conflict_idle got pops=%0d pushes=%0d expected 0/0", popCount - p0, pushCount - q0);
      end
      applyStimulus(1'b0, 1'b0, 16'h0000, 1'b1);
      tick(1);
      applyStimulus(1'b0, 1'b0, 16'h0000, 1'b0);
   endtask

   task automatic test_reset_mid;
      int p0;
      setSp(16'h4000);
      applyStimulus(1'b1, 1'b0, 16'h1357, 1'b0);
      tick(1);
      applyStimulus(1'b0, 1'b0, 16'h0000, 1'b0);
      tick(3);
      applyStimulus(1'b0, 1'b1, 16'h0000, 1'b0);
      tick(1);
      applyStimulus(1'b0, 1'b0, 16'h0000, 1'b0);
      tick(1);
      reset = 1'b0;
      #1;
      checks++;
      if ({sp_enable, sp_decrement, sp_increment, busy} !== 4'b0000 || pc_out !== 16'h0000) begin
         errors++; $display("[TB] FAIL reset_mid got %b/%h expected 0000/0000", {sp_enable, sp_decrement, sp_increment, busy}, pc_out);
      end
      tick(1);
      reset = 1'b1;
      tick(1);
      setSp(16'h0200);
      p0 = pushCount;
      applyStimulus(1'b1, 1'b0, 16'hBEEF, 1'b0);
      tick(1);
      applyStimulus(1'b0, 1'b0, 16'h0000, 1'b0);
      checks++;
      if (sp_enable !== 1'b1 || sp_decrement !== 1'b1 || sp_data_in !== 8'hBE) begin
         errors++; $display("[TB] FAIL beef_hi got en=%b data=%h expected 1/BE", sp_enable, sp_data_in);
      end
      tick(1);
      checks++;
      if (sp_enable !== 1'b1 || sp_data_in !== 8'hEF) begin
         errors++; $display("[TB] FAIL beef_lo got en=%b data=%h expected 1/EF", sp_enable, sp_data_in);
      end
      tick(1);
      checks++;
      if (done !== 1'b1 || pushCount - p0 !== 2) begin
         errors++; $display("[TB] FAIL beef_done got done=%b pushes=%0d expected 1/2", done, pushCount - p0);
      end
      tick(1);
   endtask

   task automatic test_busy_ignore;
      int p0;
      int q0;
      setSp(16'h3000);
      applyStimulus(1'b1, 1'b0, 16'hC0DE, 1'b0);
      tick(1);
      applyStimulus(1'b0, 1'b0, 16'h0000, 1'b0);
      tick(3);
      p0 = popCount;
      q0 = pushCount;
      applyStimulus(1'b0, 1'b1, 16'h0000, 1'b0);
      tick(1);
      for (int i = 0; i < 3; i++) begin
         applyStimulus(1'b1, 1'b0, 16'($urandom), 1'b0);
         tick(1);
      end
      applyStimulus(1'b0, 1'b0, 16'h0000, 1'b0);
      checks++;
      if (pc_load !== 1'b1 || pc_out !== 16'hC0DE) begin
         errors++; $display("[TB] FAIL busy_ret got load=%b pc=%h expected 1/C0DE", pc_load, pc_out);
      end
      tick(2);
      checks++;
      if (popCount - p0 !== 2 || pushCount - q0 !== 0) begin
         errors++; $display("[TB] FAIL busy_counts got pops=%0d pushes=%0d expected 2/0", popCount - p0, pushCount - q0);
      end
   endtask

   task automatic test_random;
      logic [15:0] saved[$];
      logic [15:0] a;
      logic [15:0] expPc;
      bit          doCall;
      setSp(16'h9000);
      for (int i = 0; i < 24; i++) begin
         doCall = (saved.size() == 0) || (saved.size() < 8 && $urandom_range(0, 1) == 1);
         if (doCall) begin
            a = 16'($urandom);
            applyStimulus(1'b1, 1'b0, a, 1'b0);
            tick(1);
            applyStimulus(1'b0, 1'b0, 16'h0000, 1'b0);
            checks++;
            if (sp_decrement !== 1'b1 || sp_data_in !== a[15:8]) begin
               errors++; $display("[TB] FAIL rnd_push_hi got %b/%h expected 1/%h", sp_decrement, sp_data_in, a[15:8]);
            end
            tick(1);
            checks++;
            if (sp_decrement !== 1'b1 || sp_data_in !== a[7:0]) begin
               errors++; $display("[TB] FAIL rnd_push_lo got %b/%h expected 1/%h", sp_decrement, sp_data_in, a[7:0]);
            end
            tick(1);
            checks++;
            if (done !== 1'b1 || pc_load !== 1'b0) begin
               errors++; $display("[TB] FAIL rnd_call_done got %b%b expected 10", done, pc_load);
            end
            tick(1);
            saved.push_back(a);
         end else begin
            expPc = saved.pop_back();
            applyStimulus(1'b0, 1'b1, 16'h0000, 1'b0);
            tick(1);
            applyStimulus(1'b0, 1'b0, 16'h0000, 1'b0);
            tick(3);
            checks++;
            if (pc_load !== 1'b1 || pc_out !== expPc) begin
               errors++; $display("[TB] FAIL rnd_ret got load=%b pc=%h expected 1/%h", pc_load, pc_out, expPc);
            end
            tick(1);
         end
         tick($urandom_range(0, 2));
      end
   endtask

   initial begin
      test_reset();
      test_call();
      test_return();
      test_overflow();
      test_underflow();
      test_reset_mid();
      test_busy_ignore();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/stack_call_ctrl.md
# stack_call_ctrl

Initiator-side controller for the byte-wide hardware stack. On a subroutine call it saves a 16-bit return address as two single-byte pushes. On a return it performs two pops and reassembles the address for the program counter. It sits between the control unit and the stack, drives the stack's enable/decrement/increment strobes, and guards against overflow and underflow before touching the stack.

## Interface

Parameters:
- SP_LIMIT, 16'h0000: lowest legal stack-pointer value; a push is never issued at this value.
- SP_EMPTY, 16'hFFFF: stack-pointer value when the stack is empty; a pop is never issued at this value.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- call_req  in  1  save ret_addr_in; sampled only in IDLE.
- ret_req  in  1  restore the address from the stack; sampled only in IDLE.
- ret_addr_in  in  16  return address to save; sampled in the cycle call_req is accepted.
- fault_clr  in  1  clears fault and fault_code.
- sp_ptr  in  16  current stack-pointer value from the stack.
- sp_data_out  in  8  pop data from the stack; valid one cycle after the pop strobe.
- sp_enable  out  1  stack operation strobe.
- sp_decrement  out  1  push strobe; qualified by sp_enable.
- sp_increment  out  1  pop strobe; qualified by sp_enable.
- sp_data_in  out  8  push data byte.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse when a call or return completes.
- pc_load  out  1  one-cycle pulse, coincident with done on a return.
- pc_out  out  16  restored address; holds its value until the next return completes.
- fault  out  1  sticky error flag.
- fault_code  out  2  00 none, 01 overflow, 10 underflow, 11 conflicting requests.

## Operation

- States: IDLE, PUSH_HI, PUSH_LO, POP_LO, POP_HI, POP_CAP, DONE.
- Stack outputs are Moore-decoded from the state. A push state drives sp_enable=1 and sp_decrement=1. A pop state drives sp_enable=1 and sp_increment=1.
- Call, in IDLE with call_req=1:
  - If sp_ptr < SP_LIMIT+2: overflow fault.
  - Otherwise latch ret_addr_in and go PUSH_HI (data = addr[15:8]) → PUSH_LO (data = addr[7:0]) → DONE → IDLE.
- Return, in IDLE with ret_req=1:
  - If sp_ptr > SP_EMPTY-2: underflow fault.
  - Otherwise go POP_LO (pop) → POP_HI (pop; capture sp_data_out into bits [7:0]) → POP_CAP (capture sp_data_out into bits [15:8]) → DONE (pc_out updated, pc_load=1) → IDLE.
- Range checks use 17-bit arithmetic so SP_LIMIT+2 and SP_EMPTY-2 cannot wrap.
- Both requests high in IDLE: code 11, no stack operation.
- On any fault:
  - State stays IDLE.
  - fault=1 and fault_code are set from the next cycle.
  - No partial push or pop is ever issued.
- While fault=1, requests are ignored. fault_clr takes priority over a new fault in the same cycle.
- Requests while busy are ignored and are not queued.
- The stack is assumed to accept every strobe. Its pointer is checked once, up front, for the whole two-byte operation.

## Timing

- Request sampled at edge T. Call: pushes in cycles T+1 and T+2, done in T+3, new request accepted at the T+4 edge.
- Return: pops in T+1 and T+2, captures at the T+2 and T+3 edges, done/pc_load in T+4.
- sp_data_in is 0 outside push states.
- Reset values: state IDLE, all strobes 0, sp_data_in 0, busy 0, done 0, pc_load 0, pc_out 0, fault 0, fault_code 00.
- Reset mid-operation aborts immediately; strobes drop asynchronously. The partially modified stack is not repaired; the stack has its own reset.

## Structure

- Shared package stack_pkg: state encoding, fault-code constants, default SP_LIMIT/SP_EMPTY.
- Single module, no sub-modules. The address latch and pop-assembly register are local.

## Test plan

- Call with ret_addr_in=16'h1234, sp_ptr=16'h0100 → push 8'h12 at T+1, 8'h34 at T+2, done at T+3, busy high T+1..T+3.
- Return with the stack model supplying 8'h34 then 8'h12, sp_ptr=16'h00FE → pops at T+1 and T+2, pc_out=16'h1234 and pc_load=1 at T+4.
- Call with sp_ptr=16'h0001 → no sp_enable; fault=1, code 01 from T+1. A following ret_req is ignored until fault_clr.
- Return with sp_ptr=16'hFFFE → code 10, no strobes. Assert call_req and ret_req together → code 11.
- Assert reset in POP_HI → strobes low immediately, pc_out=0. After release, a call of 16'hBEEF runs normally.
- Pulse call_req during a return → ignored; exactly two pops, no push.
